// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU execute-stage controller and its decoder.
package alu_pkg;

    localparam int WORD = 32;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS subset decoder: instruction word to ALU control and write-back info.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  func,
    output logic        use_imm,
    output logic [4:0]  dest,
    output logic        wen,
    output logic        is_beq,
    output logic        illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    // rs and shamt fields do not affect decode
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        func    = ALU_ADD;
        use_imm = 1'b0;
        dest    = 5'd0;
        is_beq  = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dest = instr[15:11];
                case (funct)
                    FN_ADD:  func = ALU_ADD;
                    FN_SUB:  func = ALU_SUB;
                    FN_AND:  func = ALU_AND;
                    FN_OR:   func = ALU_OR;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                use_imm = 1'b1;
                dest    = instr[20:16];
            end
            OP_BEQ: begin
                func   = ALU_SUB;
                is_beq = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dest = 5'd0;
        end
    end

    // writes to $0 are dropped but the destination number is still reported
    assign wen = !illegal && !is_beq && (dest != 5'd0);

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller: accepts an instruction, drives the external ALU
// through registered operands, and returns a write-back record.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int WORD = alu_pkg::WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    input  logic [WORD-1:0] rs_val,
    input  logic [WORD-1:0] rt_val,
    output logic [WORD-1:0] alu_inA,
    output logic [WORD-1:0] alu_inB,
    output logic [2:0]      alu_func,
    input  logic [WORD-1:0] alu_out,
    input  logic            alu_zero,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [WORD-1:0] res_data,
    output logic [4:0]      res_dest,
    output logic            res_wen,
    output logic            branch_taken,
    output logic            err
);

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     instr_q;
    logic [WORD-1:0] rs_q;
    logic [WORD-1:0] rt_q;
    logic [WORD-1:0] imm_sext;

    logic [2:0]      dec_func;
    logic            dec_use_imm;
    logic [4:0]      dec_dest;
    logic            dec_wen;
    logic            dec_is_beq;
    logic            dec_illegal;

    alu_decode u_decode (
        .instr   (instr_q),
        .func    (dec_func),
        .use_imm (dec_use_imm),
        .dest    (dec_dest),
        .wen     (dec_wen),
        .is_beq  (dec_is_beq),
        .illegal (dec_illegal)
    );

    assign imm_sext    = {{(WORD-16){instr_q[15]}}, instr_q[15:0]};
    assign instr_ready = (state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (instr_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = dec_illegal ? ST_WB : ST_EXEC;
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB:     if (res_valid && res_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q      <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            alu_inA      <= '0;
            alu_inB      <= '0;
            alu_func     <= ALU_ADD;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_dest     <= 5'd0;
            res_wen      <= 1'b0;
            branch_taken <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (state == ST_IDLE && instr_valid) begin
                instr_q <= instr;
                rs_q    <= rs_val;
                rt_q    <= rt_val;
            end
            if (state == ST_DECODE) begin
                if (dec_illegal) begin
                    // ALU operands are left as they were for an illegal instruction
                    res_data     <= '0;
                    res_dest     <= 5'd0;
                    res_wen      <= 1'b0;
                    branch_taken <= 1'b0;
                    err          <= 1'b1;
                end else begin
                    alu_inA  <= rs_q;
                    alu_inB  <= dec_use_imm ? imm_sext : rt_q;
                    alu_func <= dec_func;
                end
            end
            if (state == ST_EXEC) begin
                res_data     <= alu_out;
                res_dest     <= dec_dest;
                res_wen      <= dec_wen;
                branch_taken <= dec_is_beq && alu_zero;
                err          <= 1'b0;
            end
            // valid rises one cycle after entering WB and drops on the handshake
            res_valid <= (state == ST_WB) && !(res_valid && res_ready);
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural 32-bit ALU alongside it.
module tb_alu_exec_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic [W-1:0]  alu_inA;
    logic [W-1:0]  alu_inB;
    logic [2:0]    alu_func;
    logic [W-1:0]  alu_out;
    logic          alu_zero;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic [4:0]    res_dest;
    logic          res_wen;
    logic          branch_taken;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.WORD(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .alu_inA      (alu_inA),
        .alu_inB      (alu_inB),
        .alu_func     (alu_func),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_dest     (res_dest),
        .res_wen      (res_wen),
        .branch_taken (branch_taken),
        .err          (err)
    );

    always_comb begin
        case (alu_func)
            3'b000:  alu_out = alu_inA & alu_inB;
            3'b001:  alu_out = alu_inA | alu_inB;
            3'b110:  alu_out = alu_inA - alu_inB;
            default: alu_out = alu_inA + alu_inB;
        endcase
        alu_zero = (alu_out == '0);
    end

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        early_ready;
        int          lat;
        logic [31:0] data;
        logic [4:0]  dest;
        logic        wen;
        logic        bt;
        logic        er;
        logic [2:0]  func;
        logic [31:0] opb;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_ready"}, 32'(instr_ready), 32'd1);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_alu_inA"}, alu_inA, 32'd0);
        check({tag, "_alu_inB"}, alu_inB, 32'd0);
        check({tag, "_alu_func"}, 32'(alu_func), 32'd2);
        check({tag, "_res_data"}, res_data, 32'd0);
        check({tag, "_res_dest"}, 32'(res_dest), 32'd0);
        check({tag, "_res_wen"}, 32'(res_wen), 32'd0);
        check({tag, "_branch"}, 32'(branch_taken), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Offers one instruction and returns the number of cycles until res_valid
    task automatic issue(input string name, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        @(negedge clk);
        check({name, "_ready_before"}, 32'(instr_ready), 32'd1);
        instr = i;
        rs_val = a;
        rt_val = b;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 32'hDEAD_BEEF;
        rs_val = 32'h1234_5678;
        rt_val = 32'h8765_4321;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, "_valid_drop"}, 32'(res_valid), 32'd0);
        check({name, "_ready_after"}, 32'(instr_ready), 32'd1);
        res_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [W-1:0] hold_data;

        //             name         instr         rs           rt           early lat data          dst  wen bt err func    opB
        vecs[0]  = '{"add",       32'h0022_1820, 32'd5,       32'd7,       1'b0, 3, 32'd12,       5'd3, 1, 0, 0, 3'b010, 32'd7};
        vecs[1]  = '{"sub",       32'h0022_2822, 32'd10,      32'd3,       1'b0, 3, 32'd7,        5'd5, 1, 0, 0, 3'b110, 32'd3};
        vecs[2]  = '{"or",        32'h0022_3025, 32'h0000_00F0, 32'h0000_000F, 1'b0, 3, 32'h0000_00FF, 5'd6, 1, 0, 0, 3'b001, 32'h0F};
        vecs[3]  = '{"and",       32'h0022_3824, 32'h0000_00FC, 32'h0000_003F, 1'b0, 3, 32'h0000_003C, 5'd7, 1, 0, 0, 3'b000, 32'h3F};
        vecs[4]  = '{"addi_m1",   32'h2024_FFFF, 32'd0,       32'd99,      1'b0, 3, 32'hFFFF_FFFF, 5'd4, 1, 0, 0, 3'b010, 32'hFFFF_FFFF};
        vecs[5]  = '{"addi_r0",   32'h2020_FFFF, 32'd0,       32'd99,      1'b0, 3, 32'hFFFF_FFFF, 5'd0, 0, 0, 0, 3'b010, 32'hFFFF_FFFF};
        vecs[6]  = '{"illegal_op", 32'hFC00_0000, 32'd1,      32'd2,       1'b0, 2, 32'd0,        5'd0, 0, 0, 1, 3'b000, 32'd0};
        vecs[7]  = '{"beq_taken", 32'h1022_0004, 32'd9,       32'd9,       1'b0, 3, 32'd0,        5'd0, 0, 1, 0, 3'b110, 32'd9};
        vecs[8]  = '{"beq_not",   32'h1022_0004, 32'd9,       32'd8,       1'b0, 3, 32'd1,        5'd0, 0, 0, 0, 3'b110, 32'd8};
        vecs[9]  = '{"add_r0",    32'h0022_0020, 32'd1,       32'd1,       1'b0, 3, 32'd2,        5'd0, 0, 0, 0, 3'b010, 32'd1};
        vecs[10] = '{"illegal_fn", 32'h0022_1821, 32'd1,      32'd2,       1'b0, 2, 32'd0,        5'd0, 0, 0, 1, 3'b000, 32'd0};
        vecs[11] = '{"addi_wrap", 32'h2024_0001, 32'h7FFF_FFFF, 32'd0,     1'b1, 3, 32'h8000_0000, 5'd4, 1, 0, 0, 3'b010, 32'd1};

        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        rs_val = '0;
        rt_val = '0;
        res_ready = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_release");

        for (int v = 0; v < 12; v++) begin
            res_ready = vecs[v].early_ready;
            issue(vecs[v].name, vecs[v].ins, vecs[v].rs, vecs[v].rt, lat);
            check({vecs[v].name, "_latency"}, 32'(lat), 32'(vecs[v].lat));
            check({vecs[v].name, "_res_data"}, res_data, vecs[v].data);
            check({vecs[v].name, "_res_dest"}, 32'(res_dest), 32'(vecs[v].dest));
            check({vecs[v].name, "_res_wen"}, 32'(res_wen), 32'(vecs[v].wen));
            check({vecs[v].name, "_branch"}, 32'(branch_taken), 32'(vecs[v].bt));
            check({vecs[v].name, "_err"}, 32'(err), 32'(vecs[v].er));
            if (!vecs[v].er) begin
                check({vecs[v].name, "_alu_func"}, 32'(alu_func), 32'(vecs[v].func));
                check({vecs[v].name, "_alu_inA"}, alu_inA, vecs[v].rs);
                check({vecs[v].name, "_alu_inB"}, alu_inB, vecs[v].opb);
            end
            handshake(vecs[v].name);
        end

        // Illegal instruction held in WB: record stable, new offers ignored
        issue("stall", 32'hFC00_0000, 32'd3, 32'd4, lat);
        check("stall_latency", 32'(lat), 32'd2);
        hold_data = res_data;
        instr_valid = 1'b1;
        instr = 32'h0022_1820;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_err", 32'(err), 32'd1);
            check("stall_res_data", res_data, hold_data);
            check("stall_res_data_zero", res_data, 32'd0);
            check("stall_instr_ready", 32'(instr_ready), 32'd0);
        end
        instr_valid = 1'b0;
        handshake("stall");
        repeat (3) @(posedge clk);
        #1;
        check("stall_no_extra_record", 32'(res_valid), 32'd0);

        // Reset while in EXEC aborts the instruction
        @(negedge clk);
        instr = 32'h0022_1820;
        rs_val = 32'd40;
        rt_val = 32'd2;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("exec_func_before_rst", 32'(alu_func), 32'd2);
        check("exec_inA_before_rst", alu_inA, 32'd40);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_exec");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_exec_no_record", 32'(res_valid), 32'd0);
        check("rst_exec_ready", 32'(instr_ready), 32'd1);

        issue("post_rst_add", 32'h0022_1820, 32'd100, 32'd23, lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_res_data", res_data, 32'd123);
        check("post_rst_res_dest", 32'(res_dest), 32'd3);
        check("post_rst_res_wen", 32'(res_wen), 32'd1);
        handshake("post_rst_add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Multi-cycle execute-stage controller that sits in front of the team's combinational 32-bit ALU and drives it. It accepts one MIPS instruction plus its two register operands over a valid/ready handshake. It decodes the opcode/funct into the ALU's 3-bit function code and presents registered operands to the ALU. It then captures the ALU result and zero flag and returns a write-back record over a second valid/ready handshake.

## Interface

- WORD, 32, datapath width (operands, result)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept (IDLE only)
- instr  in  32  MIPS instruction word
- rs_val  in  WORD  value of register rs
- rt_val  in  WORD  value of register rt
- alu_inA  out  WORD  registered ALU operand A
- alu_inB  out  WORD  registered ALU operand B
- alu_func  out  3  registered ALU function code
- alu_out  in  WORD  ALU result (combinational from alu_inA/inB/func)
- alu_zero  in  1  ALU zero flag
- res_valid  out  1  write-back record valid
- res_ready  in  1  consumer accepts record
- res_data  out  WORD  captured result
- res_dest  out  5  destination register number
- res_wen  out  1  register write required
- branch_taken  out  1  beq resolved taken
- err  out  1  illegal instruction

## Operation

- Function codes: ADD=3'b010, SUB=3'b110, AND=3'b000, OR=3'b001.
- Decode:
  - opcode 000000 with funct 100000 → ADD, rs, rt, dest rd
  - funct 100010 → SUB
  - funct 100100 → AND
  - funct 100101 → OR
  - opcode 001000 (addi) → ADD, rs, sign-extended imm[15:0], dest rt
  - opcode 000100 (beq) → SUB, rs, rt, no dest
  - anything else is illegal.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr, rs_val and rt_val; go to DECODE.
  - DECODE: register alu_inA, alu_inB and alu_func. Legal instructions go to EXEC. Illegal instructions go to WB with err=1, res_data=0, res_wen=0, branch_taken=0, and the ALU outputs unchanged.
  - EXEC: capture alu_out into res_data. For beq, set branch_taken=alu_zero; otherwise branch_taken=0. Go to WB.
  - WB: res_valid=1 with the record held stable. On res_ready, go to IDLE.
- res_wen=1 for R-type and addi only when dest≠0. Writes to $0 are suppressed: res_wen=0, but res_dest still shows 0. For beq, res_dest=0 and res_wen=0.
- Arithmetic is performed in the ALU only. The sign extension is {{(WORD-16){imm[15]}},imm}. Overflow is ignored (wraps mod 2^WORD).
- instr_valid is ignored outside IDLE. There is no instruction queueing.

## Timing

- Accept edge is T0. alu_inA/inB/func are valid after T1. res_data is captured at T2. res_valid=1 from the T3 edge onward. With res_ready held high, the next instr_ready=1 follows the T3 edge plus one cycle.
- Illegal path: res_valid=1 after the T2 edge (one cycle shorter).
- res_ready is sampled only in WB. An early res_ready has no effect.
- Reset values (asynchronous, immediate): state IDLE, instr_ready=1, res_valid=0, alu_inA=0, alu_inB=0, alu_func=3'b010, res_data=0, res_dest=0, res_wen=0, branch_taken=0, err=0.
- Reset mid-operation aborts the instruction. No record is emitted.
- err, branch_taken and res_* change only on the EXEC/DECODE→WB transition or on reset.

## Structure

- Shared package alu_pkg holds:
  - the ALU function-code constants
  - the opcode/funct constants
  - the WORD default
  - the state enum
- One combinational sub-module, alu_decode, maps instr → {func, use_imm, dest, wen, is_beq, illegal}. It is reusable by a later pipelined control path.
- The FSM and registers live in alu_exec_ctrl. The bench instantiates the existing ALU alongside it.

## Test plan

- add $3,$1,$2 with rs_val=5, rt_val=7 → alu_func=010, then res_data=12, res_dest=3, res_wen=1, err=0, res_valid 3 cycles after accept.
- sub then or: sub with rs=10, rt=3 → res_data=7. Then or with 0xF0, 0x0F → res_data=0xFF, func=001.
- addi $4,$1,-1 with rs_val=0 → res_data=0xFFFFFFFF, res_dest=4, res_wen=1. Same with dest $0 → res_wen=0.
- beq with rs=rt=9 → branch_taken=1, res_wen=0. With rs=9, rt=8 → branch_taken=0.
- Illegal opcode 111111 → err=1, res_valid 2 cycles after accept, res_data=0. Hold res_ready=0 for 5 cycles → record stable, instr_ready=0.
- Assert rst while in EXEC → all outputs at reset values immediately. After release, instr_ready=1 and the next add completes normally.
